// File: rtl/i2c_reg_ctrl.sv
// i2c_reg_ctrl: sequences i2c slave byte events into pointer-addressed config register reads/writes
module i2c_reg_ctrl #(
   parameter logic [6:0] DEV_ADDR = 7'h2A,
   parameter int         NUM_REGS = 8,
   parameter logic [7:0] ID_VAL   = 8'hA5
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    ev_start,
   input  logic                    ev_stop,
   input  logic                    rx_valid,
   input  logic [7:0]              rx_data,
   output logic                    ack_o,
   input  logic                    tx_req,
   input  logic                    mst_nack,
   output logic [7:0]              tx_data,
   output logic                    tx_valid,
   output logic [8*NUM_REGS-1:0]   regs_o,
   output logic                    wr_stb,
   output logic [3:0]              wr_idx,
   output logic                    busy
);
   localparam int         IW   = $clog2(NUM_REGS);
   localparam logic [7:0] NR   = 8'(NUM_REGS);
   localparam logic [7:0] LAST = 8'(NUM_REGS - 1);

   typedef enum logic [2:0] {IDLE, ADDR, PTR, WRITE, READ, IGNORE} state_t;

   state_t     state, state_nx;
   logic [7:0] ptr;
   logic [7:0] regs [NUM_REGS];
   logic       in_range;
   logic [7:0] ptr_inc;
   logic [7:0] rd_byte;

   // state register
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;

   // next state: START always restarts addressing, STOP always idles
   always_comb begin
      state_nx = state;
      case (state)
         ADDR:    if (rx_valid) state_nx = (rx_data[7:1] != DEV_ADDR) ? IGNORE : rx_data[0] ? READ : PTR;
         PTR:     if (rx_valid) state_nx = WRITE;
         READ:    if (mst_nack) state_nx = IGNORE;
         default: ;
      endcase
      if (ev_stop)  state_nx = IDLE;
      if (ev_start) state_nx = ADDR;
   end

   // decoded pointer helpers; out-of-range pointers (including the ID slot) never advance
   always_comb begin
      in_range = ptr < NR;
      ptr_inc  = !in_range ? ptr : (ptr == LAST) ? 8'h00 : ptr + 8'h01;
      rd_byte  = in_range ? regs[ptr[IW-1:0]] : (ptr == 8'hFF) ? ID_VAL : 8'h00;
      busy     = state != IDLE;
   end

   // registered byte responses, register bank and pointer
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         ptr      <= '0;
         ack_o    <= 1'b0;
         tx_data  <= '0;
         tx_valid <= 1'b0;
         wr_stb   <= 1'b0;
         wr_idx   <= '0;
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      end else begin
         tx_valid <= 1'b0;
         wr_stb   <= 1'b0;
         case (state)
            ADDR: if (rx_valid) ack_o <= rx_data[7:1] == DEV_ADDR;
            PTR: if (rx_valid) begin
               ptr   <= rx_data;
               ack_o <= (rx_data < NR) || (rx_data == 8'hFF);
            end
            WRITE: if (rx_valid) begin
               ack_o <= in_range;
               if (in_range) begin
                  regs[ptr[IW-1:0]] <= rx_data;
                  wr_stb            <= 1'b1;
                  wr_idx            <= ptr[3:0];
                  ptr               <= ptr_inc;
               end
            end
            READ: if (tx_req) begin
               tx_valid <= 1'b1;
               tx_data  <= rd_byte;
               ptr      <= ptr_inc;
            end
            IGNORE: begin
               if (rx_valid) ack_o <= 1'b0;
               if (tx_req) begin
                  tx_valid <= 1'b1;
                  tx_data  <= 8'hFF;
               end
            end
            default: ;
         endcase
      end

   for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
      assign regs_o[8*g +: 8] = regs[g];
   end
endmodule

// File: tb/tb_i2c_reg_ctrl.sv
// tb_i2c_reg_ctrl: directed-vector bench for the i2c register sequencer
module tb_i2c_reg_ctrl;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        ev_start = 1'b0, ev_stop = 1'b0, rx_valid = 1'b0, tx_req = 1'b0, mst_nack = 1'b0;
   logic [7:0]  rx_data = '0;
   logic        ack_o, tx_valid, wr_stb, busy;
   logic [7:0]  tx_data;
   logic [63:0] regs_o;
   logic [3:0]  wr_idx;
   int          checks = 0;
   int          failures = 0;

   i2c_reg_ctrl dut (
      .clk(clk), .rst_n(rst_n), .ev_start(ev_start), .ev_stop(ev_stop),
      .rx_valid(rx_valid), .rx_data(rx_data), .ack_o(ack_o), .tx_req(tx_req),
      .mst_nack(mst_nack), .tx_data(tx_data), .tx_valid(tx_valid), .regs_o(regs_o),
      .wr_stb(wr_stb), .wr_idx(wr_idx), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic start();
      @(negedge clk) ev_start = 1'b1;
      @(negedge clk) ev_start = 1'b0;
   endtask

   task automatic stop();
      @(negedge clk) ev_stop = 1'b1;
      @(negedge clk) ev_stop = 1'b0;
   endtask

   task automatic rx(input logic [7:0] b);
      @(negedge clk) begin rx_valid = 1'b1; rx_data = b; end
      @(negedge clk) rx_valid = 1'b0;
   endtask

   task automatic tx();
      @(negedge clk) tx_req = 1'b1;
      @(negedge clk) tx_req = 1'b0;
   endtask

   task automatic nack();
      @(negedge clk) mst_nack = 1'b1;
      @(negedge clk) mst_nack = 1'b0;
   endtask

   initial begin
      #12;
      chk("rst_ack", ack_o, 0);
      chk("rst_txv", tx_valid, 0);
      chk("rst_txd", tx_data, 0);
      chk("rst_regs", regs_o, 0);
      chk("rst_stb", wr_stb, 0);
      chk("rst_idx", wr_idx, 0);
      chk("rst_busy", busy, 0);
      @(negedge clk) rst_n = 1'b1;

      // idle ignores tx_req
      tx();
      chk("idle_txv", tx_valid, 0);

      // burst write from reg3
      start();
      chk("t1_busy", busy, 1);
      rx(8'h54); chk("t1_ack_addr", ack_o, 1);
      rx(8'h03); chk("t1_ack_ptr", ack_o, 1);
      rx(8'h11); chk("t1_ack_d0", ack_o, 1); chk("t1_stb0", wr_stb, 1); chk("t1_idx0", wr_idx, 3);
      rx(8'h22); chk("t1_ack_d1", ack_o, 1); chk("t1_stb1", wr_stb, 1); chk("t1_idx1", wr_idx, 4);
      stop();
      chk("t1_stb_clr", wr_stb, 0);
      chk("t1_idle", busy, 0);
      chk("t1_regs", regs_o, 64'h00000022_11000000);
      chk("t1_ptr", dut.ptr, 5);

      // pointer wrap at the last register
      start(); rx(8'h54); rx(8'h07); rx(8'hAA); rx(8'hBB); stop();
      chk("t2_regs", regs_o, 64'hAA000022_110000BB);
      chk("t2_ptr", dut.ptr, 1);

      // read through repeated START
      start(); rx(8'h54); rx(8'h03);
      start(); rx(8'h55); chk("t3_ack_addr", ack_o, 1);
      tx(); chk("t3_v0", tx_valid, 1); chk("t3_d0", tx_data, 8'h11);
      tx(); chk("t3_d1", tx_data, 8'h22);
      tx(); chk("t3_d2", tx_data, 8'h00); chk("t3_ptr", dut.ptr, 6);
      nack();
      tx(); chk("t3_ign_v", tx_valid, 1); chk("t3_ign_d", tx_data, 8'hFF);
      chk("t3_busy", busy, 1);
      stop(); chk("t3_idle", busy, 0);

      // address miss
      start();
      rx(8'h56); chk("t4_ack_addr", ack_o, 0);
      rx(8'h05); chk("t4_ack_d", ack_o, 0); chk("t4_stb", wr_stb, 0);
      chk("t4_regs", regs_o, 64'hAA000022_110000BB);
      tx(); chk("t4_txv", tx_valid, 1); chk("t4_txd", tx_data, 8'hFF);
      stop();

      // out-of-range pointer and ID slot
      start(); rx(8'h54);
      rx(8'h09); chk("t5_ack_ptr", ack_o, 0);
      rx(8'h77); chk("t5_ack_wr", ack_o, 0); chk("t5_stb", wr_stb, 0);
      start(); rx(8'h55);
      tx(); chk("t5_rd9", tx_data, 8'h00); chk("t5_ptr9", dut.ptr, 9);
      stop();
      chk("t5_regs", regs_o, 64'hAA000022_110000BB);
      start(); rx(8'h54);
      rx(8'hFF); chk("t5_ack_ff", ack_o, 1);
      start(); rx(8'h55);
      tx(); chk("t5_id0", tx_data, 8'hA5);
      tx(); chk("t5_id1", tx_data, 8'hA5); chk("t5_ptrff", dut.ptr, 8'hFF);
      stop();

      // async reset right after a write strobe
      start(); rx(8'h54); rx(8'h00); rx(8'h5A);
      chk("t6_stb", wr_stb, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("t6_regs", regs_o, 0);
      chk("t6_ack", ack_o, 0);
      chk("t6_stb_clr", wr_stb, 0);
      chk("t6_busy", busy, 0);
      chk("t6_ptr", dut.ptr, 0);
      @(negedge clk) rst_n = 1'b1;
      start(); rx(8'h54); rx(8'h00);
      rx(8'h3C); chk("t6_wr_stb", wr_stb, 1); chk("t6_wr_idx", wr_idx, 0);
      stop();
      chk("t6_wr_regs", regs_o, 64'h3C);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
